// File: rtl/codec_i2c_pkg.sv
// codec_i2c_pkg: shared state encoding, reset-register address and default device address
//   Holds the responder state enum, RESET_REG, DEF_DEV_ADDR and a 3-input majority helper.
package codec_i2c_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP} state_e;
    localparam logic [6:0] RESET_REG    = 7'h0F;
    localparam logic [6:0] DEF_DEV_ADDR = 7'h1A;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronises SCL/SDA and detects SCL edges, START and STOP
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_scl, i_sda   : raw bus lines
//   o_sda          : synchronised (optionally filtered) SDA level
//   o_scl_rise/o_scl_fall/o_start/o_stop : one-cycle event pulses
//   Optional 3-sample majority filter enabled by defining I2C_RESP_GLITCH_FILTER_EN.
module i2c_line_sync
    import codec_i2c_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_w, sda_w;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i_scl};
            sda_sync_q <= {sda_sync_q[0], i_sda};
            scl_prev_q <= scl_w;
            sda_prev_q <= sda_w;
        end
    end

`ifdef I2C_RESP_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_filt_q, sda_filt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_filt_q <= maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
            sda_filt_q <= maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
        end
    end

    assign scl_w = scl_filt_q;
    assign sda_w = sda_filt_q;
`else
    assign scl_w = scl_sync_q[1];
    assign sda_w = sda_sync_q[1];
`endif

    assign o_sda      = sda_w;
    assign o_scl_rise = scl_w & ~scl_prev_q;
    assign o_scl_fall = ~scl_w & scl_prev_q;
    // SCL must be high both before and after the SDA transition.
    assign o_start    = scl_w & scl_prev_q & sda_prev_q & ~sda_w;
    assign o_stop     = scl_w & scl_prev_q & ~sda_prev_q & sda_w;
endmodule

// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder: write-only I2C responder driving a 9-bit codec-style register file
//   i_clk, i_rst_n        : system clock, async active-low reset
//   i_scl, i_sda          : I2C bus lines; o_sda_oe pulls SDA low when 1
//   o_wr_valid/addr/data  : commit pulse and last committed address/data
//   o_err                 : pulse on an acknowledged write to an unimplemented register
//   i_rd_addr, o_rd_data  : combinational register read port
//   o_busy                : high while a transaction is in progress
//   Define I2C_RESP_GLITCH_FILTER_EN to add a majority glitch filter on the bus lines.
module i2c_codec_responder
    import codec_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
    parameter int         NREG     = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    output logic       o_err,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic       o_busy
);
    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] byte1_q, byte1_d;
    logic       oe_q, oe_d;
    logic       wr_valid_q, err_q;
    logic [6:0] wr_addr_q;
    logic [8:0] wr_data_q;
    logic [8:0] regs_q [NREG];
    logic       sda, scl_rise, scl_fall, start, stop;
    logic       commit, is_rst, in_range;
    logic [7:0] rx_byte;
    logic [6:0] reg_addr;

    i2c_line_sync u_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_sda      (sda),
        .o_scl_rise (scl_rise),
        .o_scl_fall (scl_fall),
        .o_start    (start),
        .o_stop     (stop)
    );

    assign rx_byte  = {shift_q, sda};
    assign reg_addr = byte1_q[7:1];
    assign is_rst   = reg_addr == RESET_REG;
    assign in_range = int'(reg_addr) < NREG;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        byte1_d = byte1_q;
        oe_d    = oe_q;
        commit  = 1'b0;
        if (start) begin
            state_d = ADDR;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
            oe_d    = 1'b0;
        end else if (scl_rise && (state_q == ADDR || state_q == BYTE1 || state_q == BYTE2)) begin
            shift_d = rx_byte[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                state_d = state_q == ADDR  ? (rx_byte == {DEV_ADDR, 1'b0} ? ACK_A : WAIT_STOP) :
                          state_q == BYTE1 ? ACK_1 : ACK_2;
                byte1_d = state_q == BYTE1 ? rx_byte : byte1_q;
                commit  = state_q == BYTE2;
            end
        end else if (scl_fall && (state_q == ACK_A || state_q == ACK_1 || state_q == ACK_2)) begin
            // First fall after the 8th bit grabs SDA, the next one releases it and moves on.
            oe_d = ~oe_q;
            if (oe_q)
                state_d = state_q == ACK_A ? BYTE1 : state_q == ACK_1 ? BYTE2 : WAIT_STOP;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 7'd0;
            byte1_q    <= 8'd0;
            oe_q       <= 1'b0;
            wr_valid_q <= 1'b0;
            err_q      <= 1'b0;
            wr_addr_q  <= 7'd0;
            wr_data_q  <= 9'd0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= 9'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            byte1_q    <= byte1_d;
            oe_q       <= oe_d;
            wr_valid_q <= commit & (is_rst | in_range);
            err_q      <= commit & ~is_rst & ~in_range;
            if (commit && (is_rst || in_range)) begin
                wr_addr_q <= reg_addr;
                wr_data_q <= {byte1_q[0], rx_byte};
            end
            for (int i = 0; i < NREG; i++)
                if (commit && is_rst)
                    regs_q[i] <= 9'd0;
                else if (commit && int'(reg_addr) == i)
                    regs_q[i] <= {byte1_q[0], rx_byte};
        end
    end

    always_comb begin
        o_rd_data = 9'd0;
        for (int i = 0; i < NREG; i++)
            if (int'(i_rd_addr) == i) o_rd_data = regs_q[i];
    end

    assign o_sda_oe   = oe_q;
    assign o_wr_valid = wr_valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_err      = err_q;
    assign o_busy     = state_q != IDLE;
endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb_i2c_codec_responder: directed table-driven bench for the I2C codec responder
module tb_i2c_codec_responder;
    localparam int Q = 10;

    logic       clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_drv = 1'b1;
    logic       sda_bus, sda_oe, wr_valid, err, busy;
    logic [6:0] wr_addr;
    logic [8:0] wr_data, rd_data;
    logic [3:0] rd_addr = 4'd0;
    int         n_tests = 0, n_fail = 0, wv_cnt = 0, err_cnt = 0;

    typedef struct {
        logic [7:0] a0, b1, b2;
        logic [2:0] acks;
        int         wv, er;
        logic [6:0] wa;
        logic [8:0] wd;
        logic [3:0] ri;
        logic [8:0] rd;
    } vec_t;
    vec_t v [7];

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_codec_responder dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_scl      (scl),
        .i_sda      (sda_bus),
        .o_sda_oe   (sda_oe),
        .o_wr_valid (wr_valid),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_err      (err),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid === 1'b1) wv_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_drv = 1'b1; wq(Q);
        scl = 1'b1;     wq(Q);
        sda_drv = 1'b0; wq(Q);
        scl = 1'b0;     wq(Q);
    endtask

    task automatic i2c_stop;
        sda_drv = 1'b0; wq(Q);
        scl = 1'b1;     wq(Q);
        sda_drv = 1'b1; wq(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b; wq(Q);
        scl = 1'b1;  wq(2 * Q);
        scl = 1'b0;  wq(Q);
    endtask

    task automatic ack_slot(output logic ack);
        sda_drv = 1'b1; wq(Q);
        scl = 1'b1;     wq(Q);
        ack = sda_oe;   wq(Q);
        scl = 1'b0;     wq(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_slot(ack);
    endtask

    task automatic xfer(input logic [7:0] a0, b1, b2, output logic [2:0] acks);
        i2c_start;
        chk("busy_after_start", busy, 1);
        send_byte(a0, acks[2]);
        send_byte(b1, acks[1]);
        send_byte(b2, acks[0]);
        i2c_stop;
        wq(4);
    endtask

    initial begin
        logic [2:0] acks;
        logic       a;
        int         wv0, er0;
        v[0] = '{8'h34, 8'h0E, 8'h42, 3'b111, 1, 0, 7'h07, 9'h042, 4'd7,  9'h042};
        v[1] = '{8'h34, 8'h06, 8'h05, 3'b111, 1, 0, 7'h03, 9'h005, 4'd3,  9'h005};
        v[2] = '{8'h34, 8'h13, 8'h80, 3'b111, 1, 0, 7'h09, 9'h180, 4'd9,  9'h180};
        v[3] = '{8'h36, 8'h0E, 8'h11, 3'b000, 0, 0, 7'h09, 9'h180, 4'd7,  9'h042};
        v[4] = '{8'h35, 8'h06, 8'h22, 3'b000, 0, 0, 7'h09, 9'h180, 4'd3,  9'h005};
        v[5] = '{8'h34, 8'h15, 8'hFF, 3'b111, 0, 1, 7'h09, 9'h180, 4'd10, 9'h000};
        v[6] = '{8'h34, 8'h1E, 8'h00, 3'b111, 1, 0, 7'h0F, 9'h000, 4'd7,  9'h000};

        wq(3);
        chk("rst_oe", sda_oe, 0);
        chk("rst_wv", wr_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_waddr", wr_addr, 0);
        chk("rst_wdata", wr_data, 0);
        chk("rst_rd0", rd_data, 0);
        rst_n = 1'b1;
        wq(5);

        for (int k = 0; k < 7; k++) begin
            wv0 = wv_cnt; er0 = err_cnt;
            xfer(v[k].a0, v[k].b1, v[k].b2, acks);
            rd_addr = v[k].ri;
            wq(1);
            chk($sformatf("v%0d_acks", k), acks, v[k].acks);
            chk($sformatf("v%0d_wv", k), wv_cnt - wv0, v[k].wv);
            chk($sformatf("v%0d_err", k), err_cnt - er0, v[k].er);
            chk($sformatf("v%0d_waddr", k), wr_addr, v[k].wa);
            chk($sformatf("v%0d_wdata", k), wr_data, v[k].wd);
            chk($sformatf("v%0d_rd", k), rd_data, v[k].rd);
            chk($sformatf("v%0d_busy", k), busy, 0);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            wq(1);
            chk($sformatf("clear_rd%0d", i), rd_data, 0);
        end

        // Repeated START in the middle of BYTE2 abandons the write to register 7.
        wv0 = wv_cnt;
        i2c_start;
        send_byte(8'h34, acks[2]);
        send_byte(8'h0E, acks[1]);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_start;
        send_byte(8'h34, acks[2]);
        send_byte(8'h08, acks[1]);
        send_byte(8'h77, acks[0]);
        i2c_stop;
        wq(4);
        chk("rs_acks", acks, 3'b111);
        chk("rs_wv", wv_cnt - wv0, 1);
        chk("rs_waddr", wr_addr, 7'h04);
        chk("rs_wdata", wr_data, 9'h077);
        rd_addr = 4'd4; wq(1);
        chk("rs_rd4", rd_data, 9'h077);
        rd_addr = 4'd7; wq(1);
        chk("rs_rd7", rd_data, 0);

        // Reset asserted in the middle of BYTE2.
        wv0 = wv_cnt;
        i2c_start;
        send_byte(8'h34, a);
        send_byte(8'h0C, a);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("mid_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_oe", sda_oe, 0);
        chk("rstmid_busy", busy, 0);
        rd_addr = 4'd4;
        #1;
        chk("rstmid_rd4", rd_data, 0);
        wq(3);
        rst_n = 1'b1;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        ack_slot(a);
        chk("rstmid_nack", a, 0);
        i2c_stop;
        wq(4);
        chk("rstmid_wv", wv_cnt - wv0, 0);
        rd_addr = 4'd6; wq(1);
        chk("rstmid_rd6", rd_data, 0);
        wv0 = wv_cnt;
        xfer(8'h34, 8'h0C, 8'h55, acks);
        chk("post_acks", acks, 3'b111);
        chk("post_wv", wv_cnt - wv0, 1);
        chk("post_waddr", wr_addr, 7'h06);
        chk("post_wdata", wr_data, 9'h055);
        chk("post_rd6", rd_data, 9'h055);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_codec_responder.md
I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, the 7-bit device address it answers to.
REQ-002 SHALL have parameter NREG, default 10, the number of implemented 9-bit registers.
REQ-003 SHALL have port i_clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port i_scl, input, 1, the asynchronous I2C clock line from the initiator.
REQ-006 SHALL have port i_sda, input, 1, the asynchronous I2C data line as seen on the bus.
REQ-007 SHALL have port o_sda_oe, output, 1; when 1, the SDA line is pulled low; the block never drives SDA high.
REQ-008 SHALL have port o_wr_valid, output, 1, a one-cycle pulse marking a committed register write.
REQ-009 SHALL have port o_wr_addr, output, 7, the register address of the last commit.
REQ-010 SHALL have port o_wr_data, output, 9, the data of the last commit.
REQ-011 SHALL have port o_err, output, 1, a one-cycle pulse when an acknowledged write targets an address ≥ NREG (other than 7'h0F).
REQ-012 SHALL have port i_rd_addr, input, 4, the asynchronous read index into the register file.
REQ-013 SHALL have port o_rd_data, output, 9, the combinational read of register i_rd_addr; it reads 0 when i_rd_addr ≥ NREG.
REQ-014 SHALL have port o_busy, output, 1; it is 1 from START until STOP or until return to IDLE.

Function
REQ-015 SHALL synchronise i_scl and i_sda with 2 flip-flops and operate only on their synchronised edges; i_clk ≥ 8× the SCL frequency.
REQ-016 SHALL detect START as a synchronised SDA fall while SCL is high, and STOP as a synchronised SDA rise while SCL is high.
REQ-017 SHALL use the states IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2 and WAIT_STOP.
REQ-018 SHALL shift in SDA, MSB first, on each synchronised SCL rise, with a 3-bit bit counter per byte.
REQ-019 SHALL, from ADDR, go to ACK_A after 8 bits when the address equals DEV_ADDR and R/W=0; otherwise it SHALL go to WAIT_STOP with no ACK.
REQ-020 SHALL, in each ACK_x state, assert o_sda_oe from the SCL fall after the 8th bit until the following SCL fall, then advance to the next state (ACK_2 → WAIT_STOP).
REQ-021 SHALL form the register address from BYTE1[7:1] and the register data from {BYTE1[0], BYTE2[7:0]}.
REQ-022 SHALL commit on the SCL rise that samples bit 0 of BYTE2, with o_wr_valid, o_wr_addr and o_wr_data updated in the next cycle.
REQ-023 SHALL make a write to address 7'h0F clear all registers to 0 and pulse o_wr_valid, without pulsing o_err.
REQ-024 SHALL NACK any byte received in WAIT_STOP, i.e. o_sda_oe stays 0.
REQ-025 SHALL, on a repeated START in any state, go to ADDR and discard any partial byte; registers are untouched.
REQ-026 SHALL, on STOP in any state, go to IDLE and release o_sda_oe within 1 cycle; an uncommitted write is discarded.
REQ-027 SHALL give START priority when START and a bit edge are detected in the same cycle.

Reset
REQ-028 SHALL, on i_rst_n=0, immediately force state IDLE, o_sda_oe=0, o_wr_valid=0, o_err=0, o_busy=0, o_wr_addr=0, o_wr_data=0, all registers to 0, and the synchronisers to 1.
REQ-029 SHALL, on reset mid-transfer, abandon the transfer, and after release SHALL wait for a fresh START.

Configuration
REQ-030 SHALL, with I2C_RESP_GLITCH_FILTER_EN defined, pass SCL and SDA through a 3-sample majority filter after the synchronisers, adding 2 cycles of latency; pulses shorter than 2 i_clk cycles are ignored.
REQ-031 SHALL, without I2C_RESP_GLITCH_FILTER_EN, use the 2-FF synchronisers only, and all latencies are as stated above.

Structure
REQ-032 SHALL place the state enum, the RESET_REG=7'h0F constant and the default DEV_ADDR in the shared package codec_i2c_pkg.
REQ-033 SHALL place synchronisation, the optional filter, and edge/START/STOP detection in the sub-module i2c_line_sync.

Verification
REQ-034 SHALL cover: write 0x34, 0x0E, 0x42 → three ACKs, o_wr_valid once, o_wr_addr=7'h07, o_wr_data=9'h042, o_rd_data[7]=9'h042.
REQ-035 SHALL cover: address byte 0x36 → no ACK, no o_wr_valid, o_busy drops at STOP.
REQ-036 SHALL cover: write 0x34, 0x1E, 0x00 (address 0x0F) after populated registers → all registers read 0, o_err=0.
REQ-037 SHALL cover: write 0x34, 0x15, 0xFF (address 0x0A ≥ NREG) → ACKs, o_err pulses once, o_wr_valid=0.
REQ-038 SHALL cover: repeated START after BYTE1, then a full write to address 0x04 → only the address 0x04 write commits.
REQ-039 SHALL cover: i_rst_n low during BYTE2 → o_sda_oe=0 immediately, no commit, and the next full transaction succeeds.
